// File: rtl/pc_gen_pkg.sv
// Shared core package: fetch redirect encoding and
// PC-generation constants.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PCSRC_NONE = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JALR = 2'b10,
        PCSRC_TRAP = 2'b11
    } pcsrc_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: execute redirect, predecode
// hints in; fetch PC, flush and RAS hit out.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             stall_f_i;
    pcsrc_e           pcsrc_e_i;
    logic [WIDTH-1:0] pc_e_i;
    logic [WIDTH-1:0] imm_e_i;
    logic [WIDTH-1:0] rs1_e_i;
    logic             call_f_i;
    logic             ret_f_i;
    logic [WIDTH-1:0] pc_f_o;
    logic [WIDTH-1:0] pc_plus4_f_o;
    logic             flush_o;
    logic             ras_hit_o;

    modport master (
        output stall_f_i, pcsrc_e_i, pc_e_i,
        output imm_e_i, rs1_e_i, call_f_i, ret_f_i,
        input  pc_f_o, pc_plus4_f_o, flush_o, ras_hit_o
    );

    modport slave (
        input  stall_f_i, pcsrc_e_i, pc_e_i,
        input  imm_e_i, rs1_e_i, call_f_i, ret_f_i,
        output pc_f_o, pc_plus4_f_o, flush_o, ras_hit_o
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; a full push overwrites
// the oldest entry, push+pop together replaces the top.
module pc_gen_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    count;

    assign top_idx = ptr - 1'b1;
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(RAS_DEPTH));

    // Pointer and occupancy; count saturates when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - 1'b1;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push && pop)
            mem[top_idx] <= push_data;
        else if (push)
            mem[ptr] <= push_data;
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect > stall > RAS > PC+4.
// Define PC_GEN_RAS_EN to build in the return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int               RAS_DEPTH = 4
) (
    input logic   clk,
    input logic   rst,
    pc_gen_if.slave bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] redir_pc;
    logic [WIDTH-1:0] jalr_sum;
    logic             redirect;
    logic             ras_hit;
    logic [WIDTH-1:0] ras_top;

    assign redirect = (bus.pcsrc_e_i != PCSRC_NONE);
    assign pc_plus4 = pc_q + WIDTH'(PC_STEP);
    assign jalr_sum = bus.rs1_e_i + bus.imm_e_i;

`ifdef PC_GEN_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_empty;
    logic ras_full;
    logic open_ok;

    assign open_ok  = !redirect && !bus.stall_f_i;
    assign ras_push = open_ok && bus.call_f_i;
    assign ras_pop  = open_ok && bus.ret_f_i && !ras_empty;
    assign ras_hit  = ras_pop;

    pc_gen_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    logic unused_ras;
    assign unused_ras = ras_full;
`else
    logic unused_hints;
    assign unused_hints = bus.call_f_i ^ bus.ret_f_i;
    assign ras_hit      = 1'b0;
    assign ras_top      = '0;
`endif

    // Execute-stage redirect target.
    always_comb begin
        redir_pc = pc_plus4;
        unique case (bus.pcsrc_e_i)
            PCSRC_BR:   redir_pc = bus.pc_e_i + bus.imm_e_i;
            PCSRC_JALR: redir_pc = {jalr_sum[WIDTH-1:1], 1'b0};
            PCSRC_TRAP: redir_pc = TRAP_VEC;
            default:    redir_pc = pc_plus4;
        endcase
    end

    // Next fetch PC by priority.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect)
            pc_next = redir_pc;
        else if (bus.stall_f_i)
            pc_next = pc_q;
        else if (ras_hit)
            pc_next = ras_top;
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_VEC;
        else
            pc_q <= pc_next;
    end

    assign bus.pc_f_o       = pc_q;
    assign bus.pc_plus4_f_o = pc_plus4;
    assign bus.flush_o      = redirect;
    assign bus.ras_hit_o    = ras_hit;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus
// reset and RAS sequences, scoreboard on fetch PC.
module tb_pc_gen;
    import pc_gen_pkg::*;

    typedef struct {
        logic        stall;
        pcsrc_e      pcsrc;
        logic [31:0] pc_e;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        call;
        logic        ret;
        logic [31:0] exp_pc;
        logic        exp_hit;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] sb[$];
    logic [31:0] cur_pc;
    vec_t        tbl[$];

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h",
                     name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input pcsrc_e src,
        input logic [31:0] pe, input logic [31:0] im,
        input logic [31:0] r1, input logic ca,
        input logic re, input logic [31:0] epc,
        input logic eh);
        vec_t v;
        v.stall = st; v.pcsrc = src; v.pc_e = pe;
        v.imm = im; v.rs1 = r1; v.call = ca;
        v.ret = re; v.exp_pc = epc; v.exp_hit = eh;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.stall_f_i = v.stall;
        bus.pcsrc_e_i = v.pcsrc;
        bus.pc_e_i    = v.pc_e;
        bus.imm_e_i   = v.imm;
        bus.rs1_e_i   = v.rs1;
        bus.call_f_i  = v.call;
        bus.ret_f_i   = v.ret;
    endtask

    // Entered 1 time unit after a rising edge.
    task automatic step(input vec_t v, input string nm);
        logic [31:0] got;
        drive(v);
        #3;
        check({nm, " flush"}, 32'(bus.flush_o),
              32'(v.pcsrc != PCSRC_NONE));
        check({nm, " hit"}, 32'(bus.ras_hit_o),
              32'(v.exp_hit));
        check({nm, " plus4"}, bus.pc_plus4_f_o,
              cur_pc + 32'd4);
        sb.push_back(v.exp_pc);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({nm, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = bus.pc_f_o;
            check({nm, " pc"}, got, sb.pop_front());
        end
        cur_pc = v.exp_pc;
    endtask

    function automatic vec_t nop(input logic [31:0] e);
        return mk(0, PCSRC_NONE, 0, 0, 0, 0, 0, e, 0);
    endfunction

    function automatic vec_t br(input logic [31:0] t);
        return mk(0, PCSRC_BR, t, 0, 0, 0, 0, t, 0);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        cur_pc = 32'h0;
        rst = 1'b0;
        drive(nop(0));
        #1 rst = 1'b1;
        #1 check("reset_state", bus.pc_f_o, 32'h0);

        tbl.push_back(nop(32'h4));
        tbl.push_back(nop(32'h8));
        tbl.push_back(mk(1, PCSRC_NONE, 0, 0, 0,
                         0, 0, 32'h8, 0));
        tbl.push_back(mk(1, PCSRC_NONE, 0, 0, 0,
                         1, 1, 32'h8, 0));
        tbl.push_back(mk(0, PCSRC_BR, 32'h30, 32'h10, 0,
                         0, 0, 32'h40, 0));
        tbl.push_back(mk(1, PCSRC_BR, 32'h30, -32'sd8, 0,
                         0, 0, 32'h28, 0));
        tbl.push_back(mk(0, PCSRC_JALR, 0, 32'h10,
                         32'h1003, 0, 0, 32'h1012, 0));
        tbl.push_back(mk(0, PCSRC_TRAP, 0, 0, 0,
                         0, 0, 32'h100, 0));
        tbl.push_back(nop(32'h104));
        tbl.push_back(mk(0, PCSRC_JALR, 0, 32'hC,
                         32'hFFFF_FFF0, 0, 0,
                         32'hFFFF_FFFC, 0));
        tbl.push_back(nop(32'h0));
        tbl.push_back(mk(0, PCSRC_BR, 32'hFFFF_FFF0,
                         32'h20, 0, 0, 0, 32'h10, 0));
        tbl.push_back(mk(0, PCSRC_JALR, 0, 32'h7, 0,
                         0, 0, 32'h6, 0));
        tbl.push_back(mk(0, PCSRC_BR, 32'h101, 0, 0,
                         0, 0, 32'h101, 0));
        tbl.push_back(mk(0, PCSRC_BR, 32'h200, 0, 0,
                         1, 1, 32'h200, 0));
        tbl.push_back(mk(0, PCSRC_TRAP, 0, 0, 0,
                         0, 0, 32'h100, 0));

        @(posedge clk);
        #1 rst = 1'b0;
        foreach (tbl[i])
            step(tbl[i], $sformatf("vec%0d", i));

        // Async reset mid-cycle with a redirect pending.
        drive(mk(0, PCSRC_BR, 32'h500, 0, 0,
                 1, 0, 0, 0));
        #2 rst = 1'b1;
        #1 check("rst_async", bus.pc_f_o, 32'h0);
        @(posedge clk);
        #1 check("rst_hold", bus.pc_f_o, 32'h0);
        drive(nop(0));
        rst = 1'b0;
        cur_pc = 32'h0;
        step(nop(32'h4), "post_rst1");
        step(nop(32'h8), "post_rst2");

`ifdef PC_GEN_RAS_EN
        step(br(32'h20), "ras_br");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 0,
                32'h24, 0), "ras_call");
        step(nop(32'h28), "ras_seq");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h24, 1), "ras_ret");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h28, 0), "ras_ret_empty");
        for (int k = 0; k < 5; k++) begin
            step(br(32'(k * 16)), $sformatf("ovf_br%0d", k));
            step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 0,
                    32'(k * 16 + 4), 0),
                 $sformatf("ovf_call%0d", k));
        end
        for (int k = 4; k >= 1; k--)
            step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                    32'(k * 16 + 4), 1),
                 $sformatf("ovf_ret%0d", k));
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h18, 0), "ovf_ret_empty");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 0,
                32'h1C, 0), "cr_call");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 1,
                32'h1C, 1), "cr_both");
        step(mk(1, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h1C, 0), "cr_stall_ret");
        step(mk(0, PCSRC_BR, 32'h1C, 0, 0, 0, 1,
                32'h1C, 0), "cr_redir_ret");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h20, 1), "cr_ret");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h24, 0), "cr_ret_empty");
`else
        step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 0,
                32'hC, 0), "noras_call");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 0, 1,
                32'h10, 0), "noras_ret");
        step(mk(0, PCSRC_NONE, 0, 0, 0, 1, 1,
                32'h14, 0), "noras_both");
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
